// File: rtl/mem_bus_arbiter_if.sv
// Request/grant bundle between the bus arbiter and its requesters (CPU sequencer + external masters).
interface mem_bus_arbiter_if #(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned ID_W    = 2
);
  logic               cpu_req;
  logic               cpu_gnt;
  logic [NUM_DEV-1:0] dev_req;
  logic [NUM_DEV-1:0] dev_gnt;
  logic               owner_valid;
  logic               owner_is_cpu;
  logic [ID_W-1:0]    owner_dev;
  logic               preempt;

  modport master (
    output cpu_req, dev_req,
    input  cpu_gnt, dev_gnt, owner_valid, owner_is_cpu, owner_dev, preempt
  );

  modport slave (
    input  cpu_req, dev_req,
    output cpu_gnt, dev_gnt, owner_valid, owner_is_cpu, owner_dev, preempt
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shared memory bus arbiter: CPU priority with one-shot device fairness, device round-robin,
// burst-limit preemption and a single dead turnaround cycle between owners.
module mem_bus_arbiter #(
  parameter int unsigned NUM_DEV   = 4,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ID_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DEV, TURN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_last;
  logic               r_dev_turn;
  logic               r_cpu_gnt;
  logic [NUM_DEV-1:0] r_dev_gnt;
  logic               r_owner_valid;
  logic               r_owner_is_cpu;
  logic [ID_W-1:0]    r_owner_dev;
  logic               r_preempt;

  logic               w_any_dev;
  logic               w_found;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_rr_win;
  logic               w_other_dev;
  logic               w_pick_dev;
  logic               w_pick_cpu;
  logic               w_at_limit;

  assign bus.cpu_gnt      = r_cpu_gnt;
  assign bus.dev_gnt      = r_dev_gnt;
  assign bus.owner_valid  = r_owner_valid;
  assign bus.owner_is_cpu = r_owner_is_cpu;
  assign bus.owner_dev    = r_owner_dev;
  assign bus.preempt      = r_preempt;

  // Round-robin search starts just after the last granted device and wraps.
  always_comb begin
    w_any_dev = |bus.dev_req;
    w_found   = 1'b0;
    w_idx     = '0;
    w_rr_win  = '0;
    for (int unsigned k = 1; k <= NUM_DEV; k++) begin
      w_idx = ID_W'((32'(r_last) + k) % NUM_DEV);
      if (!w_found && bus.dev_req[w_idx]) begin
        w_found  = 1'b1;
        w_rr_win = w_idx;
      end
    end
    w_other_dev = |(bus.dev_req & ~(NUM_DEV'(1) << r_owner_dev));
    w_pick_dev  = w_any_dev && (r_dev_turn || !bus.cpu_req);
    w_pick_cpu  = bus.cpu_req && !(r_dev_turn && w_any_dev);
    w_at_limit  = (r_cnt == CNT_W'(BURST_MAX - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_last         <= ID_W'(NUM_DEV - 1);
      r_dev_turn     <= 1'b0;
      r_cpu_gnt      <= 1'b0;
      r_dev_gnt      <= '0;
      r_owner_valid  <= 1'b0;
      r_owner_is_cpu <= 1'b0;
      r_owner_dev    <= '0;
      r_preempt      <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE, TURN: begin
          if (w_pick_dev) begin
            r_state        <= OWN_DEV;
            r_cnt          <= '0;
            r_last         <= w_rr_win;
            r_dev_turn     <= 1'b0;
            r_cpu_gnt      <= 1'b0;
            r_dev_gnt      <= NUM_DEV'(1) << w_rr_win;
            r_owner_valid  <= 1'b1;
            r_owner_is_cpu <= 1'b0;
            r_owner_dev    <= w_rr_win;
          end else if (w_pick_cpu) begin
            r_state        <= OWN_CPU;
            r_cpu_gnt      <= 1'b1;
            r_dev_gnt      <= '0;
            r_owner_valid  <= 1'b1;
            r_owner_is_cpu <= 1'b1;
            r_owner_dev    <= '0;
          end else begin
            r_state        <= IDLE;
            r_cpu_gnt      <= 1'b0;
            r_dev_gnt      <= '0;
            r_owner_valid  <= 1'b0;
            r_owner_is_cpu <= 1'b0;
            r_owner_dev    <= '0;
          end
        end
        OWN_CPU: begin
          if (!bus.cpu_req) begin
            r_state        <= TURN;
            r_cpu_gnt      <= 1'b0;
            r_owner_valid  <= 1'b0;
            r_owner_is_cpu <= 1'b0;
            if (w_any_dev) r_dev_turn <= 1'b1;
          end
        end
        OWN_DEV: begin
          if (!bus.dev_req[r_owner_dev] || (w_at_limit && (bus.cpu_req || w_other_dev))) begin
            r_state       <= TURN;
            r_dev_gnt     <= '0;
            r_owner_valid <= 1'b0;
            r_owner_dev   <= '0;
            r_preempt     <= bus.dev_req[r_owner_dev];
          end else if (!w_at_limit) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter against an ownership-level reference model.
module tb_mem_bus_arbiter;
  localparam int unsigned NUM_DEV   = 4;
  localparam int unsigned BURST_MAX = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned ID_W      = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_bus_arbiter_if #(.NUM_DEV(NUM_DEV), .ID_W(ID_W)) bus ();

  mem_bus_arbiter #(
    .NUM_DEV(NUM_DEV), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W), .ID_W(ID_W)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: who owns the bus (0 none, 1 cpu, 2 device) and for how many edges.
  int m_kind, m_dev, m_held, m_last;
  bit m_turn, m_pre;

  function automatic int rr_pick(input int last, input logic [NUM_DEV-1:0] req);
    for (int i = 1; i <= int'(NUM_DEV); i++) begin
      int d;
      d = (last + i) % int'(NUM_DEV);
      if (req[d]) return d;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_kind = 0; m_dev = 0; m_held = 0; m_last = int'(NUM_DEV) - 1; m_turn = 0; m_pre = 0;
    end else begin
      bit any, rivals;
      any    = (bus.dev_req != '0);
      rivals = bus.cpu_req || ((bus.dev_req & ~(NUM_DEV'(1) << m_dev)) != '0);
      m_pre  = 0;
      if (m_kind == 1) begin
        if (!bus.cpu_req) begin
          m_kind = 0;
          if (any) m_turn = 1;
        end
      end else if (m_kind == 2) begin
        if (!bus.dev_req[m_dev]) m_kind = 0;
        else if (m_held >= int'(BURST_MAX) - 1 && rivals) begin
          m_kind = 0; m_pre = 1;
        end else m_held++;
      end else begin
        if (any && (m_turn || !bus.cpu_req)) begin
          m_turn = 0; m_dev = rr_pick(m_last, bus.dev_req); m_last = m_dev;
          m_kind = 2; m_held = 0;
        end else if (bus.cpu_req) m_kind = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [NUM_DEV-1:0] exp_dg;
    exp_dg = (m_kind == 2) ? (NUM_DEV'(1) << m_dev) : '0;
    check("cpu_gnt", 32'(bus.cpu_gnt), 32'(m_kind == 1));
    check("dev_gnt", 32'(bus.dev_gnt), 32'(exp_dg));
    check("owner_valid", 32'(bus.owner_valid), 32'(m_kind != 0));
    check("owner_is_cpu", 32'(bus.owner_is_cpu), 32'(m_kind == 1));
    check("owner_dev", 32'(bus.owner_dev), (m_kind == 2) ? 32'(m_dev) : 32'd0);
    check("preempt", 32'(bus.preempt), 32'(m_pre));
    total++;
    assert ($onehot0({bus.cpu_gnt, bus.dev_gnt})) else begin
      bad++;
      $display("FAIL onehot grants cpu=%0b dev=%0b t=%0t", bus.cpu_gnt, bus.dev_gnt, $time);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  int hold [NUM_DEV];
  int cpu_hold;

  initial begin
    bus.cpu_req = 1'b0;
    bus.dev_req = '0;
    #1;
    check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("rst_dev_gnt", 32'(bus.dev_gnt), 32'd0);
    check("rst_valid", 32'(bus.owner_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    // CPU tenure and its turnaround
    tick(); tick();
    bus.cpu_req = 1'b1;
    tick();
    check("t1_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("t1_is_cpu", 32'(bus.owner_is_cpu), 32'd1);
    repeat (3) tick();
    bus.cpu_req = 1'b0;
    tick();
    check("t1_turn_valid", 32'(bus.owner_valid), 32'd0);
    tick();
    check("t1_idle_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);

    // Round-robin between dev1 and dev3
    do_reset();
    bus.dev_req = 4'b1010;
    tick();
    check("t2_first", 32'(bus.dev_gnt), 32'b0010);
    for (int t = 0; t < 8; t++) begin
      logic [NUM_DEV-1:0] cur;
      cur = bus.dev_gnt;
      tick(); tick();
      bus.dev_req = 4'b1010 & ~cur;
      tick();
      check("t2_turn", 32'(bus.dev_gnt), 32'd0);
      bus.dev_req = 4'b1010;
      tick();
      check("t2_rr", 32'(bus.dev_gnt), (cur == 4'b0010) ? 32'b1000 : 32'b0010);
    end
    bus.dev_req = '0;
    tick(); tick();

    // Burst-limit preemption of dev2 by the CPU
    bus.dev_req = 4'b0100;
    tick();
    check("t3_gnt", 32'(bus.dev_gnt), 32'b0100);
    bus.cpu_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("t3_hold", 32'(bus.dev_gnt), 32'b0100);
    end
    tick();
    check("t3_preempt", 32'(bus.preempt), 32'd1);
    check("t3_drop", 32'(bus.dev_gnt), 32'd0);
    tick();
    check("t3_cpu", 32'(bus.cpu_gnt), 32'd1);
    check("t3_pulse_end", 32'(bus.preempt), 32'd0);

    // One-shot device fairness after CPU release
    bus.dev_req = 4'b0001;
    bus.cpu_req = 1'b0;
    tick();
    check("t4_turn", 32'(bus.owner_valid), 32'd0);
    bus.cpu_req = 1'b1;
    tick();
    check("t4_dev0", 32'(bus.dev_gnt), 32'b0001);
    check("t4_nocpu", 32'(bus.cpu_gnt), 32'd0);
    bus.dev_req = '0;
    tick();
    check("t4_turn2", 32'(bus.owner_valid), 32'd0);
    tick();
    check("t4_cpu", 32'(bus.cpu_gnt), 32'd1);

    // Lone device never preempted
    bus.dev_req = 4'b0010;
    bus.cpu_req = 1'b0;
    tick(); tick();
    check("t5_gnt", 32'(bus.dev_gnt), 32'b0010);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.dev_gnt != 4'b0010 || bus.preempt) check("t5_hold", {bus.preempt, 27'd0, bus.dev_gnt}, 32'b0010);
    end
    check("t5_end", 32'(bus.dev_gnt), 32'b0010);

    // Asynchronous reset mid-tenure
    #3 reset = 1'b0;
    #1;
    check("t6_async_gnt", 32'(bus.dev_gnt), 32'd0);
    check("t6_async_valid", 32'(bus.owner_valid), 32'd0);
    bus.dev_req = 4'b1111;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    tick();
    check("t6_dev0", 32'(bus.dev_gnt), 32'b0001);

    // Randomized requesters
    bus.dev_req = '0;
    bus.cpu_req = 1'b0;
    tick(); tick();
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < int'(NUM_DEV); d++) begin
        if (bus.dev_req[d]) begin
          if (bus.dev_gnt[d]) begin
            if (hold[d] <= 1) bus.dev_req[d] = 1'b0;
            else hold[d]--;
          end else if ($urandom_range(0, 39) == 0) bus.dev_req[d] = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
          bus.dev_req[d] = 1'b1;
          hold[d] = int'($urandom_range(1, 24));
        end
      end
      if (bus.cpu_req) begin
        if (bus.cpu_gnt) begin
          if (cpu_hold <= 1) bus.cpu_req = 1'b0;
          else cpu_hold--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        bus.cpu_req = 1'b1;
        cpu_hold = int'($urandom_range(1, 12));
      end
      tick();
    end

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates ownership of the shared address/memory bus between the CPU control sequencer and NUM_DEV external bus masters (DMA/peripherals).
- Requesters use a req/gnt handshake. The CPU request comes from the controller's bus request line; CPU grant feeds back as its memory acknowledge.
- Provides a fixed CPU priority with a one-shot device-fairness rule, round-robin among devices, a device burst limit with preemption, and a one-cycle turnaround between owners.

Parameters:
NUM_DEV, 4, number of external bus masters (2..8)
BURST_MAX, 16, max device tenure in cycles before it may be preempted (2..256)
CNT_W, 8, width of tenure counter; must satisfy 2^CNT_W >= BURST_MAX
ID_W, 2, width of device index; must satisfy 2^ID_W >= NUM_DEV

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU requests bus (level, held until done)
cpu_gnt  output  1  CPU owns bus
dev_req  input  NUM_DEV  per-device request (level)
dev_gnt  output  NUM_DEV  per-device grant, one-hot or zero
owner_valid  output  1  some requester owns the bus
owner_is_cpu  output  1  owner is CPU
owner_dev  output  ID_W  index of owning device (valid when owner_valid && !owner_is_cpu)
preempt  output  1  one-cycle pulse: device tenure forcibly ended

Behaviour:
- Reset (reset low, async):
  - All outputs go to 0 immediately; state = IDLE; tenure counter = 0.
  - RR pointer last_dev = NUM_DEV-1, so device 0 is searched first; fairness flag dev_turn = 0.
  - Deassertion is synchronised; the first arbitration happens at the first rising edge with reset high.
- State register: IDLE, OWN_CPU, OWN_DEV, TURN. All grant/owner outputs are decoded from registered state only; no combinational req->gnt path.
- Arbitration, evaluated at an edge in IDLE or TURN:
  - If dev_turn=1 and any dev_req: grant the RR winner device, clear dev_turn.
  - Else if cpu_req: grant the CPU.
  - Else if any dev_req: grant the RR winner device.
  - Else go to IDLE.
- RR winner: first set dev_req bit searching from last_dev+1 upward, mod NUM_DEV. On a device grant, last_dev = winner.
- Latency: a request sampled at edge k in IDLE/TURN gives a grant high from edge k (visible in cycle k..k+1). Minimum request-to-grant latency is 1 edge.
- OWN_CPU:
  - Stays while cpu_req=1.
  - On cpu_req=0 sampled: go to TURN. If any dev_req=1 at that edge, set dev_turn=1.
  - CPU is never preempted.
- OWN_DEV:
  - Counter resets to 0 on entry and increments each cycle, saturating at BURST_MAX-1.
  - On dev_req[owner]=0 sampled: go to TURN.
  - Else if counter==BURST_MAX-1 and (cpu_req or any other dev_req): go to TURN and pulse preempt for 1 cycle.
  - Else if counter==BURST_MAX-1 with no competitor: the owner keeps the bus indefinitely.
- Preempted device: sees dev_gnt fall with its req still high. It must stall and keep req asserted; it re-enters RR normally with no extra priority.
- TURN: exactly one cycle with all grants 0 (bus turnaround); arbitration is performed at its closing edge.
- Release-to-next-grant: owner req low sampled at edge k gives grants low after k and the new grant after k+1. Back-to-back tenures always have exactly one dead cycle.
- Requests that drop before being granted are ignored; no state is retained for them.
- dev_req bits for a device not yet granted have no effect on the current owner except via the burst-limit preemption rule.
- Invariant: at most one of cpu_gnt/dev_gnt is high in any cycle. A bench assertion checks this.
- Reset mid-tenure: grants drop asynchronously. The owner must abandon its transfer. No TURN cycle is inserted after reset release.

Test Plan:
- Idle, cpu_req rises at edge 5 -> cpu_gnt=1 after edge 5, owner_is_cpu=1. cpu_req falls at edge 9 -> TURN cycle, all grants 0, then IDLE.
- dev_req=4'b1010 from reset, held -> dev_gnt=0010 (dev1). Dev1 drops req -> one TURN cycle, then dev_gnt=1000 (dev3). Dev3 drops -> dev1 regranted; RR order verified for 8 tenures.
- Dev2 owns and holds req; cpu_req rises -> dev2 keeps gnt until counter reaches 15 (BURST_MAX=16). preempt pulses for 1 cycle, TURN, then cpu_gnt=1.
- CPU owns while dev0 requests. CPU releases while also re-raising cpu_req right after TURN -> dev0 granted first (dev_turn). CPU granted after dev0 releases.
- Dev1 alone holds req for 40 cycles -> no preempt, counter saturates at 15, dev_gnt stays 0010.
- Assert reset low mid-OWN_DEV -> dev_gnt=0 and owner_valid=0 in the same cycle, with no clock edge needed. After release with dev_req=1111 -> dev0 granted first.
